// File: rtl/uptimer_pkg.sv
// Shared types and defaults for the up-counting interval timer.
package uptimer_pkg;

   // Default width of count, limit and capture values.
   localparam int unsigned UPTIMER_WIDTH = 32;

   // Controller state encoding; kept as plain constants so the encoding
   // stays visible and matches the legacy down-counter.
   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'b00;
   localparam state_t RUN  = 2'b01;
   localparam state_t HOLD = 2'b10;

endpackage

// File: rtl/upcounter.sv
// Count register: synchronous clear beats increment, async active-high reset.
module upcounter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   output logic [WIDTH-1:0] Q
);

   // Clear to zero, or advance by one (wrapping modulo 2^WIDTH).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Q <= '0;
      end else if (CLR) begin
         Q <= '0;
      end else if (EN) begin
         Q <= Q + 1'b1;
      end
   end

endmodule

// File: rtl/uptimer.sv
// Programmable up-counting interval timer with one-shot / periodic modes.
// Counts 0..LIMIT, then emits a one-cycle TC pulse and sets a sticky DONE.
// Optional macro UPTIMER_CAPTURE_EN adds CAP input and CAPQ snapshot output.
module uptimer
   import uptimer_pkg::*;
#(
   parameter int unsigned WIDTH = UPTIMER_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic             STOP,
   input  logic             AUTO,
   input  logic             CLR,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             DONE,
   output logic             BUSY
`ifdef UPTIMER_CAPTURE_EN
   ,
   input  logic             CAP,
   output logic [WIDTH-1:0] CAPQ
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] limit;
   logic             terminal;
   logic             cnt_clr;
   logic             cnt_en;
   logic             tc_nxt;

   // Greater-or-equal so a LIMIT lowered below Q terminates without wrapping.
   assign terminal = (Q >= limit);

   upcounter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .CLR (cnt_clr),
      .EN  (cnt_en),
      .Q   (Q)
   );

   // Next-state and counter control, RUN priority: STOP, START, terminal, count.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      tc_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               state_nxt = RUN;
               cnt_clr   = 1'b1;
            end
         end
         RUN: begin
            if (STOP) begin
               state_nxt = HOLD;
            end else if (START) begin
               cnt_clr = 1'b1;
            end else if (terminal) begin
               tc_nxt = 1'b1;
               if (AUTO) begin
                  cnt_clr = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         HOLD: begin
            if (!STOP && START) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, BUSY and TC registers; BUSY tracks the registered state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         BUSY  <= 1'b0;
         TC    <= 1'b0;
      end else begin
         state <= state_nxt;
         BUSY  <= (state_nxt == RUN);
         TC    <= tc_nxt;
      end
   end

   // LIMIT register, loadable in any state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         limit <= '0;
      end else if (LD) begin
         limit <= D;
      end
   end

   // Sticky DONE: a terminal event on the same edge overrides CLR.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DONE <= 1'b0;
      end else if (tc_nxt) begin
         DONE <= 1'b1;
      end else if (CLR) begin
         DONE <= 1'b0;
      end
   end

`ifdef UPTIMER_CAPTURE_EN
   // Snapshot the pre-update count while RUN or HOLD.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CAPQ <= '0;
      end else if (CAP && (state == RUN || state == HOLD)) begin
         CAPQ <= Q;
      end
   end
`endif

endmodule
